// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - size codes, FSM state encodings and alignment helpers for mem_access_unit
package mem_access_unit_pkg;

    localparam int MAU_ADDR_WIDTH = 32;
    localparam int MAU_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        MAU_SIZE_B = 2'b00,
        MAU_SIZE_H = 2'b01,
        MAU_SIZE_W = 2'b10,
        MAU_SIZE_X = 2'b11
    } mau_size_e;

    typedef enum logic [1:0] {
        MAU_ST_IDLE = 2'd0,
        MAU_ST_ACC  = 2'd1,
        MAU_ST_WR   = 2'd2,
        MAU_ST_RESP = 2'd3
    } mau_state_e;

    function automatic logic mau_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            MAU_SIZE_B: return 1'b0;
            MAU_SIZE_H: return addr_lo[0];
            MAU_SIZE_W: return (addr_lo != 2'b00);
            default:    return 1'b1;
        endcase
    endfunction

    // Clears the low address bits a size cannot use (illegal size behaves as word).
    function automatic logic [1:0] mau_align_lo(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            MAU_SIZE_B: return addr_lo;
            MAU_SIZE_H: return {addr_lo[1], 1'b0};
            default:    return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and data RAM signal bundle for mem_access_unit
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [1:0]            req_size_i;
    logic                  req_unsigned_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  rsp_valid_o;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  ram_we_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [DATA_WIDTH-1:0] ram_wdata_o;
    logic [DATA_WIDTH-1:0] ram_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  ram_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output ram_we_o, ram_addr_o, ram_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output ram_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  ram_we_o, ram_addr_o, ram_wdata_o
    );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - combinational load lane extract/extend and sub-word store merge
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [1:0]            i_addr_lo,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_load_data,
    output logic [DATA_WIDTH-1:0] o_store_data
);
    logic [4:0]            w_sh_b;
    logic [4:0]            w_sh_h;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_mask;

    assign w_sh_b = {i_addr_lo, 3'b000};
    assign w_sh_h = {i_addr_lo[1], 4'b0000};
    assign w_byte = i_rdata[w_sh_b +: 8];
    assign w_half = i_rdata[w_sh_h +: 16];

    always_comb begin
        o_load_data  = i_rdata;
        o_store_data = i_wdata;
        w_mask       = '0;
        case (i_size)
            MAU_SIZE_B: begin
                o_load_data  = {{(DATA_WIDTH-8){~i_unsigned & w_byte[7]}}, w_byte};
                w_mask       = DATA_WIDTH'(8'hFF) << w_sh_b;
                o_store_data = (i_rdata & ~w_mask) | (DATA_WIDTH'(i_wdata[7:0]) << w_sh_b);
            end
            MAU_SIZE_H: begin
                o_load_data  = {{(DATA_WIDTH-16){~i_unsigned & w_half[15]}}, w_half};
                w_mask       = DATA_WIDTH'(16'hFFFF) << w_sh_h;
                o_store_data = (i_rdata & ~w_mask) | (DATA_WIDTH'(i_wdata[15:0]) << w_sh_h);
            end
            default: begin
                o_load_data  = i_rdata;
                o_store_data = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data RAM initiator; optional MAU_MISALIGN_ERR_EN reports misaligned requests
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = MAU_ADDR_WIDTH,
    parameter int DATA_WIDTH = MAU_DATA_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mem_access_unit_if.slave bus
);
    mau_state_e            r_state;
    logic                  r_we;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [1:0]            r_addr_lo;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_wdata;

    logic                  w_accept;
    logic                  w_req_err;
    logic [1:0]            w_req_size;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic                  w_req_word_st;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_accept = bus.req_valid_i && (r_state == MAU_ST_IDLE);

`ifdef MAU_MISALIGN_ERR_EN
    assign w_req_err  = mau_misaligned(bus.req_size_i, bus.req_addr_i[1:0]);
    assign w_req_size = bus.req_size_i;
    assign w_req_addr = bus.req_addr_i;
`else
    assign w_req_err  = 1'b0;
    assign w_req_size = (bus.req_size_i == MAU_SIZE_X) ? MAU_SIZE_W : bus.req_size_i;
    assign w_req_addr = {bus.req_addr_i[ADDR_WIDTH-1:2],
                         mau_align_lo(bus.req_size_i, bus.req_addr_i[1:0])};
`endif

    assign w_req_word_st = bus.req_we_i && (w_req_size == MAU_SIZE_W);

    mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane_align (
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_addr_lo    (r_addr_lo),
        .i_rdata      (bus.ram_rdata_i),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_data (w_merged)
    );

    // RAM address and word-store enable are set at accept so they are already valid in ACC.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= MAU_ST_IDLE;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_addr_lo   <= 2'b00;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            case (r_state)
                MAU_ST_IDLE: begin
                    if (w_accept) begin
                        r_we        <= bus.req_we_i;
                        r_size      <= w_req_size;
                        r_unsigned  <= bus.req_unsigned_i;
                        r_addr_lo   <= w_req_addr[1:0];
                        r_wdata     <= bus.req_wdata_i;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= w_req_err;
                        r_ram_addr  <= {w_req_addr[ADDR_WIDTH-1:2], 2'b00};
                        r_ram_wdata <= bus.req_wdata_i;
                        if (w_req_err) begin
                            r_ram_we    <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= MAU_ST_RESP;
                        end else begin
                            r_ram_we    <= w_req_word_st;
                            r_state     <= MAU_ST_ACC;
                        end
                    end
                end
                MAU_ST_ACC: begin
                    if (!r_we) begin
                        r_rsp_rdata <= w_load_data;
                        r_rsp_valid <= 1'b1;
                        r_state     <= MAU_ST_RESP;
                    end else if (r_size == MAU_SIZE_W) begin
                        r_ram_we    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= MAU_ST_RESP;
                    end else begin
                        r_ram_wdata <= w_merged;
                        r_ram_we    <= 1'b1;
                        r_state     <= MAU_ST_WR;
                    end
                end
                MAU_ST_WR: begin
                    r_ram_we    <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= MAU_ST_RESP;
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_state     <= MAU_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o = (r_state == MAU_ST_IDLE);
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_err_o   = r_rsp_err;
    assign bus.rsp_rdata_o = r_rsp_rdata;
    assign bus.ram_we_o    = r_ram_we;
    assign bus.ram_addr_o  = r_ram_addr;
    assign bus.ram_wdata_o = r_ram_wdata;

endmodule
